status_flag_unit: RTL and testbench
===================================

STATUS_FLAG_UNIT -- requirements
Module: status_flag_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the ALU operand and result width.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port exe_cmd, input, 4 bits: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR; all other codes are NOP.
REQ-005 SHALL have port val1, input, WIDTH bits, operand A.
REQ-006 SHALL have port val2, input, WIDTH bits, operand B.
REQ-007 SHALL have port s_en, input, 1 bit, a request to update flags from the current operation.
REQ-008 SHALL have port freeze, input, 1 bit, a pipeline stall that blocks all SR writes.
REQ-009 SHALL have port flush, input, 1 bit, which kills the current operation's flag update.
REQ-010 SHALL have port sr_wr_en, input, 1 bit, a direct SR write (MSR-style).
REQ-011 SHALL have port sr_wr_data, input, 4 bits {N,Z,C,V}, the direct-write value.
REQ-012 SHALL have port alu_res, output, WIDTH bits, the combinational operation result.
REQ-013 SHALL have port sr, output, 4 bits {N,Z,C,V}: bit3 N, bit2 Z, bit1 C, bit0 V.
REQ-014 SHALL have port sr_upd, output, 1 bit, a registered pulse that is high the cycle after sr changes source.

Function
REQ-015 SHALL compute alu_res as follows: MOV=val2; MVN=~val2; ADD=val1+val2; ADC=val1+val2+C; SUB=val1-val2; SBC=val1-val2-!C; AND/ORR/EOR bitwise; NOP=0.
REQ-016 SHALL compute N as alu_res[WIDTH-1] and Z as (alu_res==0) for every command, including NOP.
REQ-017 SHALL, for ADD/ADC, set C to the carry out of bit WIDTH-1 using a WIDTH+1 wide sum.
REQ-018 SHALL, for SUB/SBC, set C to NOT borrow, i.e. C=1 when no borrow occurs.
REQ-019 SHALL compute V for add operations as (A[msb]==B[msb]) && (R[msb]!=A[msb]).
REQ-020 SHALL compute V for subtract operations as (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
REQ-021 SHALL have logic operations, MOV, MVN and NOP leave C and V at their current sr values.
REQ-022 SHALL select the next SR value, in priority order: rst -> 0000; freeze -> hold; sr_wr_en -> sr_wr_data; s_en && !flush -> computed flags; otherwise hold.
REQ-023 SHALL have a direct write override a simultaneous s_en flag update in the same cycle.
REQ-024 SHALL use sr only as captured at the prior edge for ADC/SBC; there is no combinational loop from next-SR to alu_res.
REQ-025 SHALL update sr with 1-cycle latency: a flag-setting operation in cycle n is visible on sr in cycle n+1.
REQ-026 SHALL set sr_upd to 1 in the cycle after any accepted write (direct or flag), and to 0 otherwise.

Reset
REQ-027 SHALL drive sr=0000 and sr_upd=0 in the cycle after rst is sampled high; alu_res stays combinational.
REQ-028 SHALL have rst override freeze, sr_wr_en and s_en; reset asserted mid-stream discards any in-flight update.

Configuration
REQ-029 SHALL, when SR_BYPASS_EN is defined, add output sr_fwd (4 bits) equal to the next-SR value as defined in REQ-022; otherwise sr_fwd equals sr.
REQ-030 SHALL, without SR_BYPASS_EN, not have sr_fwd depend combinationally on any input.

Structure
REQ-031 SHALL place the exe_cmd encodings and the SR bit index constants (N=3, Z=2, C=1, V=0) in shared package cpu_pkg.
REQ-032 SHALL implement the combinational result and flag computation in sub-module flag_gen; status_flag_unit holds the register, priority logic and bypass.

Verification
REQ-033 SHALL cover: ADD 0xFFFFFFFF+1 with s_en=1 -> alu_res=0, next-cycle sr=0110 (Z=1, C=1).
REQ-034 SHALL cover: SUB 0x80000000-1 with s_en=1 -> alu_res=0x7FFFFFFF, sr=0011 (C=1, V=1).
REQ-035 SHALL cover: with sr=0010, ADC 5+5 -> alu_res=11; then AND 0xF0&0x0F with s_en -> sr=0110 (C kept).
REQ-036 SHALL cover: s_en=1 with freeze=1 or flush=1 -> sr unchanged and sr_upd=0 the next cycle.
REQ-037 SHALL cover: sr_wr_en=1 with sr_wr_data=1001 while s_en=1 on ADD 1+1 -> sr=1001 and sr_upd=1.
REQ-038 SHALL cover: rst=1 concurrent with sr_wr_en=1 -> sr=0000; with SR_BYPASS_EN defined, sr_fwd equals the next value in the same cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU definitions.
//   - exe_cmd_e : execute-stage command encodings (any other code is a NOP)
//   - SR_N/SR_Z/SR_C/SR_V : bit positions inside the 4-bit status register
//   - add_ovf/sub_ovf : signed-overflow helpers that work on operand/result MSBs
package cpu_pkg;

    typedef enum logic [3:0] {
        CMD_NOP = 4'b0000,
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } exe_cmd_e;

    localparam int unsigned SR_N = 3;
    localparam int unsigned SR_Z = 2;
    localparam int unsigned SR_C = 1;
    localparam int unsigned SR_V = 0;

    // Overflow on addition: operands agree in sign, result sign differs.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Overflow on subtraction: operands differ in sign, result sign differs from A.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/flag_gen.sv
// flag_gen: combinational ALU result and candidate NZCV flags.
// Ports:
//   exe_cmd  [3:0]       command code (cpu_pkg::exe_cmd_e, unknown codes = NOP)
//   val1     [WIDTH-1:0] operand A
//   val2     [WIDTH-1:0] operand B
//   sr_c, sr_v           registered C and V (carry-in for ADC/SBC, kept by non-arith ops)
//   alu_res  [WIDTH-1:0] operation result
//   flags    [3:0]       candidate {N,Z,C,V}
module flag_gen
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]       exe_cmd,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic             sr_c,
    input  logic             sr_v,
    output logic [WIDTH-1:0] alu_res,
    output logic [3:0]       flags
);

    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] res;
    logic             c_flag;
    logic             v_flag;

    // Arithmetic is done one bit wider so bit WIDTH holds the carry (add)
    // or the borrow (subtract); C for subtraction is the inverted borrow.
    always_comb begin
        wide   = '0;
        res    = '0;
        c_flag = sr_c;
        v_flag = sr_v;
        case (exe_cmd)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_ADD, CMD_ADC: begin
                wide = {1'b0, val1} + {1'b0, val2};
                if (exe_cmd == CMD_ADC) begin
                    wide = wide + {{WIDTH{1'b0}}, sr_c};
                end
                res    = wide[WIDTH-1:0];
                c_flag = wide[WIDTH];
                v_flag = add_ovf(val1[WIDTH-1], val2[WIDTH-1], res[WIDTH-1]);
            end
            CMD_SUB, CMD_SBC: begin
                wide = {1'b0, val1} - {1'b0, val2};
                if (exe_cmd == CMD_SBC) begin
                    wide = wide - {{WIDTH{1'b0}}, ~sr_c};
                end
                res    = wide[WIDTH-1:0];
                c_flag = ~wide[WIDTH];
                v_flag = sub_ovf(val1[WIDTH-1], val2[WIDTH-1], res[WIDTH-1]);
            end
            CMD_AND: res = val1 & val2;
            CMD_ORR: res = val1 | val2;
            CMD_EOR: res = val1 ^ val2;
            default: res = '0;
        endcase
    end

    always_comb begin
        alu_res       = res;
        flags         = '0;
        flags[SR_N]   = res[WIDTH-1];
        flags[SR_Z]   = (res == '0);
        flags[SR_C]   = c_flag;
        flags[SR_V]   = v_flag;
    end

endmodule

// File: rtl/status_flag_unit.sv
// status_flag_unit: ALU status register (NZCV) with update priority and optional bypass.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   exe_cmd [3:0]       command code; val1/val2 [WIDTH-1:0] operands
//   s_en                request flag update from current operation
//   freeze              stall: blocks every SR write
//   flush               cancels the current operation's flag update
//   sr_wr_en, sr_wr_data[3:0]  direct SR write, wins over s_en
//   alu_res [WIDTH-1:0] combinational result
//   sr [3:0]            registered {N,Z,C,V}
//   sr_upd              high the cycle after an accepted SR write
//   sr_fwd [3:0]        with SR_BYPASS_EN defined: next-SR value (same cycle);
//                       otherwise equal to sr (registered only)
module status_flag_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       exe_cmd,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic             s_en,
    input  logic             freeze,
    input  logic             flush,
    input  logic             sr_wr_en,
    input  logic [3:0]       sr_wr_data,
    output logic [WIDTH-1:0] alu_res,
    output logic [3:0]       sr,
    output logic             sr_upd,
    output logic [3:0]       sr_fwd
);

    logic [3:0] sr_q, sr_d;
    logic       sr_upd_q, sr_upd_d;
    logic [3:0] flags;

    // Carry-in comes from the registered SR only, so there is no loop
    // through the next-state logic.
    flag_gen #(
        .WIDTH(WIDTH)
    ) u_flag_gen (
        .exe_cmd (exe_cmd),
        .val1    (val1),
        .val2    (val2),
        .sr_c    (sr_q[SR_C]),
        .sr_v    (sr_q[SR_V]),
        .alu_res (alu_res),
        .flags   (flags)
    );

    always_comb begin
        sr_d     = sr_q;
        sr_upd_d = 1'b0;
        if (freeze) begin
            sr_d = sr_q;
        end else if (sr_wr_en) begin
            sr_d     = sr_wr_data;
            sr_upd_d = 1'b1;
        end else if (s_en && !flush) begin
            sr_d     = flags;
            sr_upd_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q     <= '0;
            sr_upd_q <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            sr_upd_q <= sr_upd_d;
        end
    end

    assign sr     = sr_q;
    assign sr_upd = sr_upd_q;

`ifdef SR_BYPASS_EN
    // Reset is folded in here because sr_d itself leaves reset to the register.
    assign sr_fwd = rst ? 4'b0000 : sr_d;
`else
    assign sr_fwd = sr_q;
`endif

endmodule

// File: tb/tb_status_flag_unit.sv
module tb_status_flag_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   exe_cmd;
    logic [W-1:0] val1, val2;
    logic         s_en, freeze, flush, sr_wr_en;
    logic [3:0]   sr_wr_data;
    logic [W-1:0] alu_res;
    logic [3:0]   sr;
    logic         sr_upd;
    logic [3:0]   sr_fwd;

    status_flag_unit #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .exe_cmd    (exe_cmd),
        .val1       (val1),
        .val2       (val2),
        .s_en       (s_en),
        .freeze     (freeze),
        .flush      (flush),
        .sr_wr_en   (sr_wr_en),
        .sr_wr_data (sr_wr_data),
        .alu_res    (alu_res),
        .sr         (sr),
        .sr_upd     (sr_upd),
        .sr_fwd     (sr_fwd)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] alu;
        logic [3:0]   sr;
        logic         upd;
        logic [3:0]   fwd;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   done   = 1'b0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // One cycle of stimulus. e_sr/e_upd are the registered outputs visible
    // during this cycle; e_nxt is the SR value after the coming edge.
    task automatic step(input string nm, input logic [3:0] cmd, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic se, input logic fz, input logic fl,
                        input logic we, input logic [3:0] wd, input logic r,
                        input logic [W-1:0] e_alu, input logic [3:0] e_sr, input logic e_upd,
                        input logic [3:0] e_nxt);
        exp_t e;
        @(posedge clk);
        #1;
        exe_cmd = cmd; val1 = a; val2 = b; s_en = se; freeze = fz; flush = fl;
        sr_wr_en = we; sr_wr_data = wd; rst = r;
        e.name = nm; e.alu = e_alu; e.sr = e_sr; e.upd = e_upd;
`ifdef SR_BYPASS_EN
        e.fwd = e_nxt;
`else
        e.fwd = e_sr;
`endif
        exp_q.push_back(e);
    endtask

    // Driver
    initial begin
        rst = 1'b1; exe_cmd = 4'h0; val1 = '0; val2 = '0; s_en = 1'b0; freeze = 1'b0;
        flush = 1'b0; sr_wr_en = 1'b0; sr_wr_data = 4'h0;
        //   name          cmd    val1          val2          se fz fl we wd     rst alu           sr     upd nxt
        step("rst_wr",     4'h0, 32'h0,        32'h0,        0, 0, 0, 1, 4'hF, 1, 32'h0,        4'h0, 0, 4'h0);
        step("add_carry",  4'h2, 32'hFFFFFFFF, 32'h1,        1, 0, 0, 0, 4'h0, 0, 32'h0,        4'h0, 0, 4'h6);
        step("sub_ovf",    4'h4, 32'h80000000, 32'h1,        1, 0, 0, 0, 4'h0, 0, 32'h7FFFFFFF, 4'h6, 1, 4'h3);
        step("msr_0010",   4'h0, 32'h0,        32'h0,        0, 0, 0, 1, 4'h2, 0, 32'h0,        4'h3, 1, 4'h2);
        step("adc_5_5",    4'h3, 32'h5,        32'h5,        0, 0, 0, 0, 4'h0, 0, 32'hB,        4'h2, 1, 4'h2);
        step("and_keep_c", 4'h6, 32'hF0,       32'h0F,       1, 0, 0, 0, 4'h0, 0, 32'h0,        4'h2, 0, 4'h6);
        step("freeze",     4'h5, 32'hA,        32'h3,        1, 1, 0, 0, 4'h0, 0, 32'h7,        4'h6, 1, 4'h6);
        step("flush",      4'h5, 32'hA,        32'h3,        1, 0, 1, 0, 4'h0, 0, 32'h7,        4'h6, 0, 4'h6);
        step("wr_over_s",  4'h2, 32'h1,        32'h1,        1, 0, 0, 1, 4'h9, 0, 32'h2,        4'h6, 0, 4'h9);
        step("sbc_c0",     4'h5, 32'hA,        32'h3,        1, 0, 0, 0, 4'h0, 0, 32'h6,        4'h9, 1, 4'h2);
        step("mvn",        4'h9, 32'h0,        32'h0,        1, 0, 0, 0, 4'h0, 0, 32'hFFFFFFFF, 4'h2, 1, 4'hA);
        step("sub_borrow", 4'h4, 32'h0,        32'h1,        1, 0, 0, 0, 4'h0, 0, 32'hFFFFFFFF, 4'hA, 1, 4'h8);
        step("add_ovf",    4'h2, 32'h7FFFFFFF, 32'h1,        1, 0, 0, 0, 4'h0, 0, 32'h80000000, 4'h8, 1, 4'h9);
        step("rst_mid",    4'h7, 32'h0F,       32'hF0,       1, 0, 0, 1, 4'h5, 1, 32'hFF,       4'h9, 1, 4'h0);
        step("eor",        4'h8, 32'hFF,       32'h0F,       0, 0, 0, 0, 4'h0, 0, 32'hF0,       4'h0, 0, 4'h0);
        step("mov_zero",   4'h1, 32'h5,        32'h0,        1, 0, 0, 0, 4'h0, 0, 32'h0,        4'h0, 0, 4'h4);
        step("nop_flags",  4'hF, 32'h5,        32'h3,        1, 0, 0, 0, 4'h0, 0, 32'h0,        4'h4, 1, 4'h4);
        step("idle1",      4'h0, 32'h0,        32'h0,        0, 0, 0, 0, 4'h0, 0, 32'h0,        4'h4, 1, 4'h4);
        step("idle2",      4'h0, 32'h0,        32'h0,        0, 0, 0, 0, 4'h0, 0, 32'h0,        4'h4, 0, 4'h4);
        done = 1'b1;
    end

    // Monitor: compares DUT outputs mid-cycle against the queued expectation.
    initial begin
        exp_t e;
        int   cycles = 0;
        while (!(done && exp_q.size() == 0)) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".alu_res"}, alu_res, e.alu);
                chk({e.name, ".sr"}, {28'h0, sr}, {28'h0, e.sr});
                chk({e.name, ".sr_upd"}, {31'h0, sr_upd}, {31'h0, e.upd});
                chk({e.name, ".sr_fwd"}, {28'h0, sr_fwd}, {28'h0, e.fwd});
            end
            cycles++;
            if (cycles > 1000) begin
                checks++;
                errors++;
                $display("FAIL timeout: got %0d cycles expected <= 1000", cycles);
                break;
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
